transit_event_logger: RTL and testbench

- Downstream consumer of a transition-output FSM's one-cycle pulses `g` and `s`.
- Each cycle in which either pulse is high is recorded as one entry: the pulse flags plus a free-running cycle timestamp.
- Entries are buffered in a small show-ahead FIFO, which a bench monitor or a host register interface drains.
- Purpose: verify the timing and ordering of on-transit outputs without waveform inspection.

---
 rtl/transit_event_logger.sv | 111 +++++++++++
 tb/tb_transit_event_logger.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/transit_event_logger.sv
// transit_event_logger
// Records every cycle in which the upstream FSM pulses g and/or s as one
// entry {g, s, ts} in a small show-ahead FIFO. ts is a free-running cycle
// counter. Overflowing events are dropped and flagged through a sticky ovf.
module transit_event_logger #(
    parameter int TS_W  = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              g,
    input  logic              s,
    input  logic              clr,
    input  logic              rd_en,
    output logic [TS_W+1:0]   rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level,
    output logic              ovf
);

    // Entry storage; not reset because level alone decides which slots are valid.
    logic [TS_W+1:0] mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [TS_W-1:0] ts_q, ts_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    logic            ev;
    logic            push;
    logic            pop;

    // Next-state logic: clr wins over everything; a pop frees a slot so a
    // simultaneous push into a full FIFO is still accepted.
    always_comb begin
        ev       = g | s;
        pop      = rd_en & ~empty_q;
        push     = ev & (~full_q | pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ts_d     = ts_q + TS_W'(1);
        ovf_d    = ovf_q;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ts_d     = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
            if (ev & full_q & ~pop) begin
                ovf_d = 1'b1;
            end
        end

        // Flags are precomputed from the next level so they leave a flop.
        empty_d = (level_d == '0);
        full_d  = (level_d == (AW+1)'(DEPTH));
    end

    // Control state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ts_q     <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ts_q     <= ts_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage write: the pre-increment timestamp is stored with the flags.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr_q] <= {g, s, ts_q};
        end
    end

    // Show-ahead head entry; forced to zero while empty so the output never
    // exposes uninitialised storage.
    assign rd_data = empty_q ? '0 : mem[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign level   = level_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_transit_event_logger.sv
// Bench for transit_event_logger: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_transit_event_logger;

    localparam int TS_W  = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic            g     = 1'b0;
    logic            s     = 1'b0;
    logic            clr   = 1'b0;
    logic            rd_en = 1'b0;
    logic [TS_W+1:0] rd_data;
    logic            empty;
    logic            full;
    logic [AW:0]     level;
    logic            ovf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [TS_W+1:0] mq[$];
    int              m_ts  = 0;
    bit              m_ovf = 1'b0;

    transit_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g       (g),
        .s       (s),
        .clr     (clr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("full",  32'(full),  32'(mq.size() == DEPTH));
        chk("level", 32'(level), 32'(mq.size()));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        if (mq.size() > 0) begin
            chk("rd_data", 32'(rd_data), 32'(mq[0]));
        end
    endtask

    // One clock of the logger's rules, expressed on a queue of entries.
    task automatic model_step(input logic ig, input logic is, input logic iclr, input logic ird);
        logic [TS_W+1:0] e;
        if (iclr) begin
            mq.delete();
            m_ts  = 0;
            m_ovf = 1'b0;
        end else begin
            if (ird && mq.size() > 0) begin
                e = mq.pop_front();
                $display("pop  g=%0d s=%0d ts=%0d level_after=%0d", e[TS_W+1], e[TS_W], e[TS_W-1:0], mq.size());
            end
            if (ig || is) begin
                if (mq.size() < DEPTH) begin
                    e = {ig, is, m_ts[TS_W-1:0]};
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                end
            end
            m_ts = (m_ts + 1) % (1 << TS_W);
        end
    endtask

    task automatic cycle(input logic ig, input logic is, input logic iclr, input logic ird);
        g     = ig;
        s     = is;
        clr   = iclr;
        rd_en = ird;
        @(posedge clk);
        model_step(ig, is, iclr, ird);
        @(negedge clk);
        check_model();
    endtask

    // Asserts reset between edges to confirm it acts without a clock, then
    // releases it on a falling edge so the next rising edge samples ts = 0.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_empty", 32'(empty),   32'd1);
        chk("rst_level", 32'(level),   32'd0);
        chk("rst_ovf",   32'(ovf),     32'd0);
        chk("rst_full",  32'(full),    32'd0);
        chk("rst_data",  32'(rd_data), 32'd0);
        mq.delete();
        m_ts  = 0;
        m_ovf = 1'b0;
        g     = 1'b0;
        s     = 1'b0;
        clr   = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int rr;

        // Idle after reset
        do_reset();
        repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle_data",  32'(rd_data), 32'd0);
        chk("idle_empty", 32'(empty),   32'd1);
        chk("idle_level", 32'(level),   32'd0);

        // Single g pulse on the 5th cycle -> ts 4
        do_reset();
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_data",  32'(rd_data), 32'({2'b10, 12'd4}));
        chk("single_level", 32'(level),   32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("single_popped_empty", 32'(empty), 32'd1);

        // g and s together at ts 7
        do_reset();
        repeat (7) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_data",  32'(rd_data), 32'({2'b11, 12'd7}));
        chk("both_level", 32'(level),   32'd1);

        // Overflow: 9 consecutive g cycles
        do_reset();
        repeat (9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ovf_full",  32'(full),  32'd1);
        chk("ovf_flag",  32'(ovf),   32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", 32'(rd_data), 32'({2'b10, 12'(i)}));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("ovf_drained_empty", 32'(empty), 32'd1);

        // Push and pop together while full
        do_reset();
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("fullpp_level", 32'(level), 32'd8);
        chk("fullpp_ovf",   32'(ovf),   32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk("fullpp_drain", 32'(rd_data), 32'({2'b10, 12'(i)}));
            cycle(1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Timestamp wrap
        do_reset();
        repeat (4095) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("wrap_first", 32'(rd_data), 32'({2'b10, 12'd4095}));
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("wrap_second", 32'(rd_data), 32'({2'b10, 12'd0}));

        // clr with 3 entries and ovf set; an event in the clr cycle is lost
        do_reset();
        repeat (9) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_pre_level", 32'(level), 32'd3);
        chk("clr_pre_ovf",   32'(ovf),   32'd1);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_empty", 32'(empty), 32'd1);
        chk("clr_level", 32'(level), 32'd0);
        chk("clr_ovf",   32'(ovf),   32'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_ts_restart", 32'(rd_data), 32'({2'b10, 12'd0}));

        // Randomized traffic, alternating drain-heavy and fill-heavy phases
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rr = ((i / 500) % 2 != 0) ? 8 : 2;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom % 4) == 0, ($urandom % 4) == 0,
                      ($urandom % 150) == 0, ($urandom % rr) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
